sid_dc_blocker: RTL and testbench

- Downstream of the SID filter/volume stage. Consumes its 18-bit signed mixed sample once per sample strobe.
- Removes DC offset with a one-pole, multiplier-free high-pass: y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> K).
- Saturates the result to a 16-bit signed PCM word for the audio mixer/DAC path.
- Sequential 4-state datapath that reuses one adder chain; one output strobe per accepted sample.

---
 rtl/sid_audio_pkg.sv | 39 +++
 rtl/sid_sat.sv | 40 ++++
 rtl/sid_dc_blocker.sv | 192 +++++++++++++++++++
 tb/tb_sid_dc_blocker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_audio_pkg.sv
// -----------------------------------------------------------------------------
// sid_audio_pkg
// Shared definitions for the SID audio back end. This package is used by the
// DC blocker and by the mixer stages that follow it.
//   - dcState_e : sequencing states of the DC blocker datapath
//   - accWidth  : accumulator width derived from the fractional guard bits
//   - LFSR_SEED / LFSR_TAPS : dither generator constants
//   - DEF_K / DEF_FRAC / DEF_OUT_W : default stage parameters
// -----------------------------------------------------------------------------
package sid_audio_pkg;

    // Width of the signed mixed sample produced by the filter/volume stage.
    localparam int SID_SAMPLE_W = 18;

    // Default leak shift, guard bits and PCM width for the audio path.
    localparam int DEF_K     = 10;
    localparam int DEF_FRAC  = 8;
    localparam int DEF_OUT_W = 16;

    // Galois LFSR used for optional output dither.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One sample enters in S_IDLE and then walks through the shared adder
    // chain once per state before the result is published in S_OUT.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIFF = 2'd1,
        S_LEAK = 2'd2,
        S_OUT  = 2'd3
    } dcState_e;

    // Two headroom bits above the 18-bit sample keep the high-pass state from
    // overflowing on a full-scale step, plus the fractional guard bits.
    function automatic int accWidth(input int frac);
        return SID_SAMPLE_W + 2 + frac;
    endfunction

endpackage

// File: rtl/sid_sat.sv
// -----------------------------------------------------------------------------
// sid_sat
// Parameterised signed saturator. Narrows a signed value of IN_W bits to OUT_W
// bits, clamping to the most positive / most negative OUT_W value instead of
// wrapping. When IN_W <= OUT_W the value is simply sign-extended.
// Ports:
//   data_i  in  IN_W   signed input value
//   data_o  out OUT_W  signed clamped value
// -----------------------------------------------------------------------------
module sid_sat #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  data_i,
    output logic signed [OUT_W-1:0] data_o
);

    generate
        if (IN_W > OUT_W) begin : g_clip
            // The value fits only if every bit from the output sign position
            // upward is a copy of the same sign.
            logic [IN_W-OUT_W:0] headBits;

            assign headBits = data_i[IN_W-1:OUT_W-1];

            // Pass the low bits through when they fit, otherwise pick the
            // rail on the side given by the true sign bit.
            always_comb begin
                data_o = data_i[OUT_W-1:0];
                if ((headBits != '0) && (headBits != '1)) begin
                    data_o = data_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                            : {1'b0, {(OUT_W-1){1'b1}}};
                end
            end
        end else begin : g_extend
            assign data_o = OUT_W'(data_i);
        end
    endgenerate

endmodule

// File: rtl/sid_dc_blocker.sv
// -----------------------------------------------------------------------------
// sid_dc_blocker
// One-pole, multiplier-free DC blocking high-pass that sits after the SID
// filter/volume stage:
//     y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> K)
// The result is saturated to an OUT_W-bit signed PCM word. A sample is
// processed over four clocks (S_IDLE, S_DIFF, S_LEAK, S_OUT) reusing one adder
// chain, producing one out_valid strobe per accepted sample.
//
// Optional build macro SID_DCBLOCK_DITHER_EN: adds a 16-bit Galois LFSR whose
// low bits are added to the accumulator before the output truncation.
//
// Ports:
//   clk        in   1      system clock
//   rst        in   1      asynchronous active-high reset
//   sound_in   in   18     signed sample from the filter stage
//   in_valid   in   1      one-cycle strobe qualifying sound_in
//   bypass     in   1      1 = pass the sample through (still saturated)
//   out        out  OUT_W  signed PCM output, held between strobes
//   out_valid  out  1      one-cycle strobe marking a new out value
//   overrun    out  1      sticky: a sample arrived while busy
// -----------------------------------------------------------------------------
module sid_dc_blocker
    import sid_audio_pkg::*;
#(
    parameter int K     = DEF_K,
    parameter int FRAC  = DEF_FRAC,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [17:0]      sound_in,
    input  logic                    in_valid,
    input  logic                    bypass,
    output logic signed [OUT_W-1:0] out,
    output logic                    out_valid,
    output logic                    overrun
);

    localparam int ACC_W = accWidth(FRAC);
    // Leak sum y + d - (y >>> K) needs two growth bits; one spare keeps the
    // saturator input comfortably wide.
    localparam int SUM_W = ACC_W + 3;
    // Fractional plus headroom bits dropped when forming the PCM word.
    localparam int SH    = FRAC + SID_SAMPLE_W - OUT_W;

    dcState_e                 state_q,    state_d;
    logic signed [ACC_W-1:0]  xNew_q,     xNew_d;
    logic signed [ACC_W-1:0]  xPrev_q,    xPrev_d;
    logic signed [ACC_W-1:0]  y_q,        y_d;
    logic signed [ACC_W:0]    d_q,        d_d;
    logic signed [OUT_W-1:0]  out_q,      out_d;
    logic                     outValid_q, outValid_d;
    logic                     overrun_q,  overrun_d;

    logic signed [ACC_W-1:0]  xIn;
    logic signed [ACC_W:0]    dDiff;
    logic signed [ACC_W-1:0]  yLeak;
    logic signed [SUM_W-1:0]  leakSum;
    logic signed [ACC_W-1:0]  accSat;
    logic        [ACC_W:0]    ditherExt;
    logic signed [ACC_W:0]    yDith;
    logic signed [ACC_W:0]    outShift;
    logic signed [OUT_W-1:0]  outSat;

    // Incoming sample scaled up by the guard bits, sign preserved.
    assign xIn = ACC_W'(sound_in) <<< FRAC;

    // First difference at one extra bit so a full-scale step cannot wrap.
    assign dDiff = {xNew_q[ACC_W-1], xNew_q} - {xPrev_q[ACC_W-1], xPrev_q};

    // Arithmetic shift rounds toward minus infinity, so negative residue
    // drains all the way to zero.
    assign yLeak   = y_q >>> K;
    assign leakSum = {{3{y_q[ACC_W-1]}}, y_q}
                   + {{2{d_q[ACC_W]}}, d_q}
                   - {{3{yLeak[ACC_W-1]}}, yLeak};

    sid_sat #(
        .IN_W  (SUM_W),
        .OUT_W (ACC_W)
    ) uAccSat (
        .data_i (leakSum),
        .data_o (accSat)
    );

`ifdef SID_DCBLOCK_DITHER_EN
    localparam logic [ACC_W:0] DITHER_MASK = (ACC_W+1)'((64'd1 << SH) - 64'd1);

    logic [15:0] lfsr_q, lfsr_d, lfsrNext;

    assign lfsrNext  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    assign ditherExt = (ACC_W+1)'(lfsr_q) & DITHER_MASK;
`else
    assign ditherExt = '0;
`endif

    // One extra bit so adding dither near the positive rail cannot wrap.
    assign yDith    = {y_q[ACC_W-1], y_q} + ditherExt;
    assign outShift = yDith >>> SH;

    sid_sat #(
        .IN_W  (ACC_W + 1),
        .OUT_W (OUT_W)
    ) uOutSat (
        .data_i (outShift),
        .data_o (outSat)
    );

    // Next-state and datapath control. Every register holds by default; each
    // state updates only the registers it owns. A strobe seen outside S_IDLE
    // is discarded and latched into the sticky overrun flag.
    always_comb begin
        state_d    = state_q;
        xNew_d     = xNew_q;
        xPrev_d    = xPrev_q;
        y_d        = y_q;
        d_d        = d_q;
        out_d      = out_q;
        outValid_d = 1'b0;
        overrun_d  = overrun_q | (in_valid && (state_q != S_IDLE));
`ifdef SID_DCBLOCK_DITHER_EN
        lfsr_d     = lfsr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    xNew_d  = xIn;
                    state_d = S_DIFF;
                end
            end
            S_DIFF: begin
                d_d     = dDiff;
                xPrev_d = xNew_q;
`ifdef SID_DCBLOCK_DITHER_EN
                lfsr_d  = lfsrNext;
`endif
                state_d = S_LEAK;
            end
            S_LEAK: begin
                // Bypass seeds y with the raw sample so that leaving bypass
                // decays from the last passed-through level.
                y_d     = bypass ? xNew_q : accSat;
                state_d = S_OUT;
            end
            S_OUT: begin
                out_d      = outSat;
                outValid_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register. Reset may land mid-sample; everything returns to zero
    // and the sample in flight is abandoned without a strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            xNew_q     <= '0;
            xPrev_q    <= '0;
            y_q        <= '0;
            d_q        <= '0;
            out_q      <= '0;
            outValid_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef SID_DCBLOCK_DITHER_EN
            lfsr_q     <= LFSR_SEED;
`endif
        end else begin
            state_q    <= state_d;
            xNew_q     <= xNew_d;
            xPrev_q    <= xPrev_d;
            y_q        <= y_d;
            d_q        <= d_d;
            out_q      <= out_d;
            outValid_q <= outValid_d;
            overrun_q  <= overrun_d;
`ifdef SID_DCBLOCK_DITHER_EN
            lfsr_q     <= lfsr_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_valid = outValid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sid_dc_blocker.sv
// -----------------------------------------------------------------------------
// tb_sid_dc_blocker
// Scoreboard bench for sid_dc_blocker (K=10, FRAC=8, OUT_W=16, no dither).
// Stimulus pushes the expected PCM value and the cycle on which its strobe
// must appear; an independent monitor pops and compares on every out_valid.
// -----------------------------------------------------------------------------
module tb_sid_dc_blocker;

    localparam longint ACC_MAX = (64'sd1 <<< 27) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< 27);

    typedef struct {
        int    value;
        int    cycle;
        string tag;
    } expect_t;

    logic               clk;
    logic               rst;
    logic signed [17:0] soundIn;
    logic               inValid;
    logic               bypass;
    logic signed [15:0] outPcm;
    logic               outValid;
    logic               overrun;

    int      checks;
    int      failures;
    int      cycleCount;
    int      strobeCount;
    expect_t sbQueue[$];
    longint  mXPrev;
    longint  mY;

    sid_dc_blocker #(
        .K     (10),
        .FRAC  (8),
        .OUT_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sound_in  (soundIn),
        .in_valid  (inValid),
        .bypass    (bypass),
        .out       (outPcm),
        .out_valid (outValid),
        .overrun   (overrun)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle stamp used to verify the three-edge latency.
    initial cycleCount = 0;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Reference of the filter equation, used for the long decay tail.
    function automatic int modelStep(input int sample, input bit byp);
        longint x, d, t;
        x = longint'(sample) * 256;
        d = x - mXPrev;
        mXPrev = x;
        if (byp) begin
            mY = x;
        end else begin
            t = mY + d - (mY >>> 10);
            if (t > ACC_MAX) t = ACC_MAX;
            else if (t < ACC_MIN) t = ACC_MIN;
            mY = t;
        end
        t = mY >>> 10;
        if (t > 32767) t = 32767;
        else if (t < -32768) t = -32768;
        return int'(t);
    endfunction

    // Drive one in_valid pulse and optionally register its expected output.
    task automatic applyStimulus(input int sample, input bit pushIt, input int expValue,
                                 input string tag, input int gap);
        expect_t e;
        @(negedge clk);
        soundIn = 18'(sample);
        inValid = 1'b1;
        if (pushIt) begin
            e.value = expValue;
            e.cycle = cycleCount + 4;
            e.tag   = tag;
            sbQueue.push_back(e);
        end
        @(negedge clk);
        inValid = 1'b0;
        soundIn = '0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mXPrev = 0;
        mY     = 0;
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while (sbQueue.size() != 0 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (sbQueue.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d pending required=0 pending", sbQueue.size());
            sbQueue.delete();
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation in
    // both value and arrival cycle; a strobe with nothing pending is an error.
    always @(negedge clk) begin
        expect_t e;
        if (outValid) begin
            strobeCount++;
            if (sbQueue.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_strobe actual out=%0d required no strobe", outPcm);
            end else begin
                e = sbQueue.pop_front();
                checkOutput({e.tag, "_value"}, outPcm, e.value);
                checkOutput({e.tag, "_latency"}, cycleCount, e.cycle);
            end
        end
    end

    // Watchdog so a stuck run still ends with a visible failure.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int zeroRun;
        int expV;
        int strobesBefore;

        checks      = 0;
        failures    = 0;
        strobeCount = 0;
        rst         = 1'b1;
        soundIn     = '0;
        inValid     = 1'b0;
        bypass      = 1'b0;
        mXPrev      = 0;
        mY          = 0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset_out", outPcm, 0);
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_overrun", overrun, 0);
        rst = 1'b0;

        // Constant 1000: step response 250, then leak pulls it to zero.
        $display("[TB] step response and decay");
        void'(modelStep(1000, 1'b0));
        applyStimulus(1000, 1'b1, 250, "step_first", 2);
        void'(modelStep(1000, 1'b0));
        applyStimulus(1000, 1'b1, 249, "step_second", 2);
        void'(modelStep(1000, 1'b0));
        applyStimulus(1000, 1'b1, 249, "step_third", 2);
        n = 0;
        zeroRun = 0;
        while (zeroRun < 8 && n < 7000) begin
            expV = modelStep(1000, 1'b0);
            applyStimulus(1000, 1'b1, expV, "decay", 2);
            zeroRun = (expV == 0) ? zeroRun + 1 : 0;
            n++;
        end
        waitDrain();

        // Full-scale steps drive the output into both clamp limits.
        $display("[TB] saturation");
        doReset();
        applyStimulus(-131072, 1'b1, -32768, "neg_full", 2);
        applyStimulus(131071, 1'b1, 32767, "pos_clamp", 2);
        applyStimulus(-131072, 1'b1, -32768, "neg_clamp", 2);
        waitDrain();

        // Bypass passes -4000 as -1000, then the leak takes over.
        $display("[TB] bypass");
        doReset();
        bypass = 1'b1;
        applyStimulus(-4000, 1'b1, -1000, "bypass_pass", 2);
        bypass = 1'b0;
        applyStimulus(-4000, 1'b1, -1000, "bypass_exit1", 2);
        applyStimulus(-4000, 1'b1, -999, "bypass_exit2", 2);
        applyStimulus(0, 1'b1, 2, "bypass_zero1", 2);
        applyStimulus(0, 1'b1, 2, "bypass_zero2", 2);
        waitDrain();

        // Busy handling: second strobe two and three edges later is dropped.
        $display("[TB] overrun");
        doReset();
        checkOutput("overrun_clear", overrun, 0);
        applyStimulus(1000, 1'b1, 250, "ovr_a_first", 0);
        applyStimulus(5000, 1'b0, 0, "ovr_a_drop", 4);
        checkOutput("overrun_set", overrun, 1);
        applyStimulus(1000, 1'b1, 249, "ovr_normal", 2);
        checkOutput("overrun_sticky", overrun, 1);
        applyStimulus(1000, 1'b1, 249, "ovr_b_first", 1);
        applyStimulus(7000, 1'b0, 0, "ovr_b_drop", 4);
        waitDrain();
        checkOutput("overrun_sticky2", overrun, 1);

        // Asynchronous reset one cycle into a sample.
        $display("[TB] async reset mid-sample");
        strobesBefore = strobeCount;
        @(negedge clk);
        soundIn = 18'sd1000;
        inValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        soundIn = '0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_out", outPcm, 0);
        checkOutput("async_overrun", overrun, 0);
        checkOutput("async_out_valid", outValid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mXPrev = 0;
        mY     = 0;
        repeat (6) @(negedge clk);
        checkOutput("async_no_strobe", strobeCount, strobesBefore);
        applyStimulus(1000, 1'b1, 250, "after_reset", 2);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
